// File: rtl/fir_mac_pkg.sv
// Shared widths, FSM state encoding and accumulator limits for the time-shared
// MAC scheduler and its round-robin arbiter.
package fir_mac_pkg;

    localparam int DEF_NUM_REQ = 4;
    localparam int DEF_DIN0_W  = 16;
    localparam int DEF_DIN1_W  = 9;
    localparam int DEF_PROD_W  = DEF_DIN0_W + DEF_DIN1_W;
    localparam int DEF_ACC_W   = 32;

    localparam logic signed [DEF_ACC_W-1:0] ACC_MAX = {1'b0, {(DEF_ACC_W-1){1'b1}}};
    localparam logic signed [DEF_ACC_W-1:0] ACC_MIN = {1'b1, {(DEF_ACC_W-1){1'b0}}};

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BURST = 2'd1,
        FLUSH = 2'd2,
        HOLD  = 2'd3
    } state_e;

    // Round-robin pointer advance with wrap at n.
    function automatic int ptr_inc(input int idx, input int n);
        return (idx + 1) % n;
    endfunction

endpackage

// File: rtl/fir_mac_scheduler_if.sv
// Requester operand bus and result bus of the MAC scheduler.
// Requests: a beat moves when req_valid[i] && req_ready[i]; results move when res_valid && res_ready.
interface fir_mac_scheduler_if #(
    parameter int NUM_REQ = 4,
    parameter int DIN0_W  = 16,
    parameter int DIN1_W  = 9,
    parameter int ACC_W   = 32
);
    localparam int IDW = $clog2(NUM_REQ);

    logic [NUM_REQ-1:0]        req_valid;
    logic [NUM_REQ-1:0]        req_ready;
    logic [NUM_REQ*DIN0_W-1:0] req_din0;
    logic [NUM_REQ*DIN1_W-1:0] req_din1;
    logic [NUM_REQ-1:0]        req_last;
    logic                      res_valid;
    logic                      res_ready;
    logic [ACC_W-1:0]          res_data;
    logic [IDW-1:0]            res_id;
    logic                      res_sat;

    modport master (
        output req_valid, req_din0, req_din1, req_last, res_ready,
        input  req_ready, res_valid, res_data, res_id, res_sat
    );

    modport slave (
        input  req_valid, req_din0, req_din1, req_last, res_ready,
        output req_ready, res_valid, res_data, res_id, res_sat
    );

endinterface

// File: rtl/fir_rr_arbiter.sv
// Combinational round-robin search: first asserted request at or above ptr_i,
// wrapping past the top index.
module fir_rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int IDW     = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req_i,
    input  logic [IDW-1:0]     ptr_i,
    output logic [IDW-1:0]     win_o,
    output logic               any_o
);

    always_comb begin
        int idx;
        win_o = '0;
        any_o = 1'b0;
        idx   = 0;
        // Walk from farthest to nearest so the nearest hit is the final write.
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = (int'(ptr_i) + k) % NUM_REQ;
            if (req_i[idx]) begin
                win_o = IDW'(idx);
                any_o = 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_mac_scheduler.sv
// Time-shares one signed multiplier among NUM_REQ requesters, one job per grant.
// Define FIR_MAC_SATURATE_EN to clamp the accumulator and report res_sat.
module fir_mac_scheduler
    import fir_mac_pkg::*;
#(
    parameter int NUM_REQ = DEF_NUM_REQ,
    parameter int DIN0_W  = DEF_DIN0_W,
    parameter int DIN1_W  = DEF_DIN1_W,
    parameter int ACC_W   = DEF_ACC_W
) (
    input  logic               ap_clk,
    input  logic               ap_rst_n,
    fir_mac_scheduler_if.slave bus,
    output logic               busy,
    output state_e             state_dbg
);

    localparam int IDW    = $clog2(NUM_REQ);
    localparam int PROD_W = DIN0_W + DIN1_W;

    state_e                     state_q;
    logic [IDW-1:0]             grant_q;
    logic [IDW-1:0]             rr_ptr_q;
    logic [NUM_REQ-1:0]         req_ready_q;
    logic                       res_valid_q;
    logic                       busy_q;
    logic signed [PROD_W-1:0]   prod_q;
    logic signed [PROD_W-1:0]   prod_d;
    logic                       pv_q;
    logic signed [ACC_W-1:0]    acc_q;
    logic signed [ACC_W-1:0]    acc_d;
    logic signed [ACC_W-1:0]    prod_ext;
    logic signed [DIN0_W-1:0]   op0;
    logic signed [DIN1_W-1:0]   op1;
    logic [IDW-1:0]             win;
    logic                       any_req;
    logic                       beat;
    logic                       beat_last;

    fir_rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .IDW     (IDW)
    ) u_arb (
        .req_i (bus.req_valid),
        .ptr_i (rr_ptr_q),
        .win_o (win),
        .any_o (any_req)
    );

    assign op0       = bus.req_din0[int'(grant_q)*DIN0_W +: DIN0_W];
    assign op1       = bus.req_din1[int'(grant_q)*DIN1_W +: DIN1_W];
    assign prod_d    = op0 * op1;
    assign beat      = (state_q == BURST) && |(bus.req_valid & req_ready_q);
    assign beat_last = beat && bus.req_last[grant_q];
    assign prod_ext  = ACC_W'(prod_q);

`ifdef FIR_MAC_SATURATE_EN
    localparam logic signed [ACC_W-1:0] SAT_MAX = {1'b0, {(ACC_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN = {1'b1, {(ACC_W-1){1'b0}}};

    logic             sat_q;
    logic             sat_d;
    logic [ACC_W:0]   sum_wide;

    // One guard bit: a disagreement between the top two bits means overflow.
    always_comb begin
        sum_wide = {acc_q[ACC_W-1], acc_q} + {prod_ext[ACC_W-1], prod_ext};
        acc_d    = sum_wide[ACC_W-1:0];
        sat_d    = sat_q;
        if (sum_wide[ACC_W] != sum_wide[ACC_W-1]) begin
            acc_d = sum_wide[ACC_W] ? SAT_MIN : SAT_MAX;
            sat_d = 1'b1;
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            sat_q <= 1'b0;
        end else if (state_q == IDLE) begin
            sat_q <= 1'b0;
        end else if (pv_q) begin
            sat_q <= sat_d;
        end
    end

    assign bus.res_sat = sat_q;
`else
    assign acc_d       = acc_q + prod_ext;
    assign bus.res_sat = 1'b0;
`endif

    // Product register feeds the accumulator one cycle later; FLUSH drains it.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            prod_q <= '0;
            pv_q   <= 1'b0;
            acc_q  <= '0;
        end else begin
            pv_q <= beat;
            if (beat) begin
                prod_q <= prod_d;
            end
            if (state_q == IDLE) begin
                acc_q <= '0;
            end else if (pv_q) begin
                acc_q <= acc_d;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            state_q     <= IDLE;
            grant_q     <= '0;
            rr_ptr_q    <= '0;
            req_ready_q <= '0;
            res_valid_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (any_req) begin
                        grant_q     <= win;
                        rr_ptr_q    <= IDW'(ptr_inc(int'(win), NUM_REQ));
                        req_ready_q <= NUM_REQ'(1) << win;
                        busy_q      <= 1'b1;
                        state_q     <= BURST;
                    end
                end
                BURST: begin
                    if (beat_last) begin
                        req_ready_q <= '0;
                        state_q     <= FLUSH;
                    end
                end
                FLUSH: begin
                    res_valid_q <= 1'b1;
                    state_q     <= HOLD;
                end
                HOLD: begin
                    if (bus.res_ready) begin
                        res_valid_q <= 1'b0;
                        busy_q      <= 1'b0;
                        state_q     <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.req_ready = req_ready_q;
    assign bus.res_valid = res_valid_q;
    assign bus.res_data  = acc_q;
    assign bus.res_id    = grant_q;
    assign busy          = busy_q;
    assign state_dbg     = state_q;

endmodule

// File: tb/tb_fir_mac_scheduler.sv
// Directed bench for fir_mac_scheduler: a 4-requester ACC_W=32 instance plus an
// ACC_W=26 instance for the accumulator overflow case.
module tb_fir_mac_scheduler;
  import fir_mac_pkg::*;

  logic   ap_clk = 1'b0;
  logic   ap_rst_n = 1'b0;
  logic   busy, busy26;
  state_e state_dbg, state_dbg26;
  int     vecs = 0;
  int     errs = 0;

  fir_mac_scheduler_if #(.NUM_REQ(4), .DIN0_W(16), .DIN1_W(9), .ACC_W(32)) bus ();
  fir_mac_scheduler_if #(.NUM_REQ(4), .DIN0_W(16), .DIN1_W(9), .ACC_W(26)) bus26 ();

  fir_mac_scheduler #(.NUM_REQ(4), .DIN0_W(16), .DIN1_W(9), .ACC_W(32)) dut (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus.slave), .busy(busy), .state_dbg(state_dbg)
  );

  fir_mac_scheduler #(.NUM_REQ(4), .DIN0_W(16), .DIN1_W(9), .ACC_W(26)) dut26 (
    .ap_clk(ap_clk), .ap_rst_n(ap_rst_n), .bus(bus26.slave), .busy(busy26), .state_dbg(state_dbg26)
  );

  always #5 ap_clk = ~ap_clk;

  task automatic do_reset;
    bus.req_valid = '0; bus.req_din0 = '0; bus.req_din1 = '0; bus.req_last = '0; bus.res_ready = 1'b1;
    bus26.req_valid = '0; bus26.req_din0 = '0; bus26.req_din1 = '0; bus26.req_last = '0;
    bus26.res_ready = 1'b1;
    ap_rst_n = 1'b0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(negedge ap_clk);
  endtask

  // Called at a negedge; returns at the negedge right after the accepting posedge.
  task automatic send_beat(input int id, input logic [15:0] d0, input logic [8:0] d1, input logic last);
    int t = 0;
    bus.req_valid[id] = 1'b1;
    bus.req_din0[id*16 +: 16] = d0;
    bus.req_din1[id*9 +: 9] = d1;
    bus.req_last[id] = last;
    while (!bus.req_ready[id] && t < 50) begin
      @(negedge ap_clk);
      t++;
    end
    if (t >= 50) begin
      vecs++; errs++;
      $display("FAIL beat_timeout req=%0d: req_ready=%b never granted", id, bus.req_ready);
    end
    @(negedge ap_clk);
    bus.req_valid[id] = 1'b0;
    bus.req_last[id] = 1'b0;
  endtask

  task automatic wait_result(input string name, input logic [31:0] exp_d, input logic [1:0] exp_id);
    int t = 0;
    while (!bus.res_valid && t < 50) begin
      @(negedge ap_clk);
      t++;
    end
    vecs++;
    if (!bus.res_valid) begin
      errs++;
      $display("FAIL %s_timeout: res_valid=0, required 1", name);
    end else begin
      vecs++;
      if (bus.res_data !== exp_d) begin
        errs++;
        $display("FAIL %s_data: got %0d, required %0d", name, $signed(bus.res_data), $signed(exp_d));
      end
      vecs++;
      if (bus.res_id !== exp_id) begin
        errs++;
        $display("FAIL %s_id: got %0d, required %0d", name, bus.res_id, exp_id);
      end
    end
    @(negedge ap_clk);
  endtask

  task automatic test_reset;
    do_reset();
    vecs++;
    if ({bus.req_ready, bus.res_valid, bus.res_sat, busy} !== 7'b0) begin
      errs++;
      $display("FAIL reset_ctrl: ready=%b res_valid=%b sat=%b busy=%b, required all 0",
               bus.req_ready, bus.res_valid, bus.res_sat, busy);
    end
    vecs++;
    if (bus.res_data !== 32'd0 || bus.res_id !== 2'd0) begin
      errs++;
      $display("FAIL reset_data: data=%0d id=%0d, required 0/0", bus.res_data, bus.res_id);
    end
    vecs++;
    if (state_dbg !== IDLE) begin
      errs++;
      $display("FAIL reset_state: got %0d, required IDLE", state_dbg);
    end
  endtask

  task automatic test_basic_job;
    do_reset();
    bus.req_valid[0] = 1'b1;
    bus.req_din0[15:0] = 16'd100;
    bus.req_din1[8:0] = 9'd3;
    @(negedge ap_clk);
    vecs++;
    if (bus.req_ready !== 4'b0001 || busy !== 1'b1) begin
      errs++;
      $display("FAIL grant_latency: ready=%b busy=%b, required 0001/1", bus.req_ready, busy);
    end
    send_beat(0, 16'd100, 9'd3, 1'b0);
    send_beat(0, -16'sd200, 9'd5, 1'b0);
    send_beat(0, 16'd7, -9'sd256, 1'b1);
    vecs++;
    if (bus.res_valid !== 1'b0 || bus.req_ready !== 4'b0000) begin
      errs++;
      $display("FAIL flush_cycle: res_valid=%b ready=%b, required 0/0000", bus.res_valid, bus.req_ready);
    end
    @(negedge ap_clk);
    vecs++;
    if (bus.res_valid !== 1'b1) begin
      errs++;
      $display("FAIL result_latency: res_valid=%b two cycles after last, required 1", bus.res_valid);
    end
    wait_result("basic", -32'sd2492, 2'd0);
  endtask

  task automatic test_round_robin;
    int got = 0;
    int t = 0;
    bit multi = 1'b0;
    logic [1:0] ids[6];
    logic [31:0] dat[6];
    do_reset();
    for (int i = 0; i < 4; i++) begin
      bus.req_din0[i*16 +: 16] = 16'(i + 1);
      bus.req_din1[i*9 +: 9] = 9'd2;
    end
    bus.req_last = 4'b1111;
    bus.req_valid = 4'b1111;
    while (got < 6 && t < 200) begin
      @(negedge ap_clk);
      t++;
      if ($countones(bus.req_ready) > 1) multi = 1'b1;
      if (bus.res_valid && bus.res_ready) begin
        ids[got] = bus.res_id;
        dat[got] = bus.res_data;
        got++;
      end
    end
    bus.req_valid = '0;
    vecs++;
    if (got != 6) begin
      errs++;
      $display("FAIL rr_count: got %0d results, required 6", got);
    end
    for (int i = 0; i < got; i++) begin
      vecs++;
      if (ids[i] !== 2'(i % 4) || dat[i] !== 32'(((i % 4) + 1) * 2)) begin
        errs++;
        $display("FAIL rr_seq[%0d]: id=%0d data=%0d, required id=%0d data=%0d",
                 i, ids[i], dat[i], i % 4, ((i % 4) + 1) * 2);
      end
    end
    vecs++;
    if (multi) begin
      errs++;
      $display("FAIL rr_onehot: req_ready had multiple bits set, required one-hot or zero");
    end
  endtask

  task automatic test_bubble;
    do_reset();
    send_beat(2, 16'd1000, 9'd10, 1'b0);
    repeat (2) @(negedge ap_clk);
    vecs++;
    if (bus.res_data !== 32'd10000) begin
      errs++;
      $display("FAIL bubble_acc_hold: acc=%0d during bubble, required 10000", bus.res_data);
    end
    send_beat(2, -16'sd1, -9'sd1, 1'b1);
    wait_result("bubble", 32'd10001, 2'd2);
    send_beat(2, 16'd1000, 9'd10, 1'b0);
    send_beat(2, -16'sd1, -9'sd1, 1'b1);
    wait_result("no_bubble", 32'd10001, 2'd2);
  endtask

  task automatic test_hold;
    int t = 0;
    bit bad = 1'b0;
    do_reset();
    bus.res_ready = 1'b0;
    send_beat(1, 16'd5, 9'd6, 1'b1);
    while (!bus.res_valid && t < 20) begin
      @(negedge ap_clk);
      t++;
    end
    bus.req_valid[0] = 1'b1;
    bus.req_din0[15:0] = 16'd9;
    bus.req_din1[8:0] = 9'd2;
    bus.req_last[0] = 1'b1;
    repeat (5) begin
      if (bus.res_valid !== 1'b1 || bus.res_data !== 32'd30 || bus.res_id !== 2'd1 || bus.req_ready !== 4'b0)
        bad = 1'b1;
      @(negedge ap_clk);
    end
    vecs++;
    if (bad) begin
      errs++;
      $display("FAIL hold_stable: outputs moved while stalled (data=%0d id=%0d ready=%b), required 30/1/0000",
               bus.res_data, bus.res_id, bus.req_ready);
    end
    bus.res_ready = 1'b1;
    @(negedge ap_clk);
    vecs++;
    if (bus.req_ready !== 4'b0000 || bus.res_valid !== 1'b0) begin
      errs++;
      $display("FAIL hold_release: ready=%b res_valid=%b in IDLE, required 0000/0", bus.req_ready, bus.res_valid);
    end
    @(negedge ap_clk);
    vecs++;
    if (bus.req_ready !== 4'b0001) begin
      errs++;
      $display("FAIL hold_regrant: ready=%b, required 0001", bus.req_ready);
    end
    @(negedge ap_clk);
    bus.req_valid[0] = 1'b0;
    bus.req_last[0] = 1'b0;
    wait_result("hold_next", 32'd18, 2'd0);
  endtask

  task automatic test_saturate;
    int t;
    logic [25:0] exp_d;
    logic exp_sat;
`ifdef FIR_MAC_SATURATE_EN
    exp_d = 26'd33554431;
    exp_sat = 1'b1;
`else
    exp_d = 26'(-25330939);
    exp_sat = 1'b0;
`endif
    do_reset();
    for (int k = 0; k < 5; k++) begin
      bus26.req_valid[0] = 1'b1;
      bus26.req_din0[15:0] = 16'd32767;
      bus26.req_din1[8:0] = 9'd255;
      bus26.req_last[0] = (k == 4);
      t = 0;
      while (!bus26.req_ready[0] && t < 50) begin
        @(negedge ap_clk);
        t++;
      end
      @(negedge ap_clk);
    end
    bus26.req_valid = '0;
    bus26.req_last = '0;
    t = 0;
    while (!bus26.res_valid && t < 50) begin
      @(negedge ap_clk);
      t++;
    end
    vecs++;
    if (bus26.res_valid !== 1'b1 || bus26.res_data !== exp_d) begin
      errs++;
      $display("FAIL sat_data: valid=%b data=%0d, required 1/%0d", bus26.res_valid,
               $signed(bus26.res_data), $signed(exp_d));
    end
    vecs++;
    if (bus26.res_sat !== exp_sat) begin
      errs++;
      $display("FAIL sat_flag: got %b, required %b", bus26.res_sat, exp_sat);
    end
    @(negedge ap_clk);
  endtask

  task automatic test_async_reset;
    do_reset();
    send_beat(3, 16'd1, 9'd1, 1'b0);
    send_beat(3, 16'd1, 9'd1, 1'b0);
    bus.req_valid[3] = 1'b1;
    #2 ap_rst_n = 1'b0;
    #1;
    vecs++;
    if (bus.req_ready !== 4'b0 || busy !== 1'b0 || bus.res_valid !== 1'b0 || bus.res_sat !== 1'b0) begin
      errs++;
      $display("FAIL async_reset_ctrl: ready=%b busy=%b res_valid=%b sat=%b, required all 0",
               bus.req_ready, busy, bus.res_valid, bus.res_sat);
    end
    vecs++;
    if (bus.res_data !== 32'd0 || bus.res_id !== 2'd0) begin
      errs++;
      $display("FAIL async_reset_data: data=%0d id=%0d, required 0/0", bus.res_data, bus.res_id);
    end
    bus.req_valid = '0;
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    bus.req_valid = 4'b1010;
    @(negedge ap_clk);
    vecs++;
    if (bus.req_ready !== 4'b0010) begin
      errs++;
      $display("FAIL post_reset_grant: ready=%b, required 0010", bus.req_ready);
    end
    bus.req_valid = '0;
  endtask

  initial begin
    test_reset();
    test_basic_job();
    test_round_robin();
    test_bubble();
    test_hold();
    test_saturate();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule

// File: doc/fir_mac_scheduler.md
# fir_mac_scheduler

Time-shared multiply-accumulate scheduler for the multirate filterbank. It lets NUM_REQ polyphase/channel requesters share one signed 16×9 multiplier, granting it to one requester per job in round-robin order. Each job is a burst of operand pairs ending with a last flag. The block returns the sign-extended accumulated sum tagged with the requester index. It sits between the per-channel tap sequencers and the output decimation stage.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- DIN0_W, 16, sample operand width (signed)
- DIN1_W, 9, coefficient operand width (signed)
- PROD_W, 25, product width; equals DIN0_W+DIN1_W
- ACC_W, 32, accumulator/result width (≥ PROD_W)
- ap_clk  in  1  clock; all state changes on the rising edge
- ap_rst_n  in  1  reset; asynchronous assert, active-low
- req_valid  in  NUM_REQ  per-requester operand-pair valid
- req_ready  out  NUM_REQ  per-requester accept; one-hot or zero
- req_din0  in  NUM_REQ*DIN0_W  packed samples; requester i at [i*DIN0_W +: DIN0_W]
- req_din1  in  NUM_REQ*DIN1_W  packed coefficients; same packing
- req_last  in  NUM_REQ  marks the final pair of a job
- res_valid  out  1  result available
- res_ready  in  1  downstream accept
- res_data  out  ACC_W  signed accumulated result
- res_id  out  $clog2(NUM_REQ)  requester index of the result
- res_sat  out  1  saturation occurred in this job; constant 0 without the macro
- busy  out  1  high in any state other than IDLE

## Operation
- FSM states: IDLE, BURST, FLUSH, HOLD.
- IDLE: if any req_valid, pick the first valid index searching upward from rr_ptr with wrap. Register the grant, set rr_ptr = winner+1 mod NUM_REQ, clear acc and sat, go to BURST. With no valid requester, stay in IDLE.
- BURST: req_ready[grant]=1; all other bits stay 0. A beat is accepted when req_valid[grant] && req_ready[grant].
  - Accepted beat: signed product of the two operands is registered in prod_q, with pipe valid pv=1.
  - Each cycle with pv=1: acc += sign-extend(prod_q).
  - Accepting a beat with req_last high goes to FLUSH; req_ready drops in the same transition.
- FLUSH: adds the final product, then goes to HOLD.
- HOLD: res_valid=1, with res_data=acc and res_id=grant. When res_ready is high, go to IDLE.
- Bubbles: if req_valid[grant] is low in BURST, nothing is accepted and acc holds. The grant is held until a last beat arrives; there is no timeout.
- Valid from non-granted requesters is ignored until the next IDLE.
- A single-beat job (last on its first beat) is legal.
- Arithmetic: full-precision signed PROD_W product. Accumulation wraps modulo 2^ACC_W (without the macro).

## Timing
- Reset values: req_ready 0, res_valid 0, res_data 0, res_id 0, res_sat 0, busy 0. Internal state: FSM IDLE, rr_ptr 0, acc 0, pv 0.
- Grant latency: valid seen in IDLE at cycle t gives req_ready at t+1.
- Result latency: last beat accepted at t gives res_valid at t+2.
- Minimum job period is N+3 cycles for N beats, with res_ready held high.
- Outputs are stable while res_valid && !res_ready.
- Reset asserted mid-job aborts immediately; outputs take reset values asynchronously and the partial sum is discarded.

## Configuration
- FIR_MAC_SATURATE_EN defined: each accumulate clamps to the signed ACC_W range, and res_sat is set sticky for the job on any clamp.
- FIR_MAC_SATURATE_EN undefined: accumulation wraps, and res_sat is tied to 0.

## Structure
- Package fir_mac_pkg holds the default widths, the state enum (IDLE/BURST/FLUSH/HOLD), and the ACC_MAX/ACC_MIN constants derived from ACC_W.
- Sub-module fir_rr_arbiter: combinational round-robin search. Inputs are the request vector and rr_ptr; outputs are the winner index and an any-valid flag.
- Multiplier and accumulator stay in the top module.

## Test plan
- Requester 0, pairs (100,3), (−200,5), (7,−256 last) → res_data −2492, res_id 0, res_valid two cycles after the last accept.
- All four requesters continuously valid with single-beat jobs → res_id sequence 0,1,2,3,0,1; req_ready never has two bits high at once.
- Requester 2, job (1000,10), (−1,−1 last) with req_valid low for 2 cycles between the beats → res_data 10001, identical to the no-bubble run.
- res_ready held low 5 cycles in HOLD → res_data/res_id stable, req_ready all 0, no new grant. Grant follows one cycle after IDLE is re-entered.
- ACC_W=26, five beats of (32767,255) → result −25330939 and res_sat 0 without FIR_MAC_SATURATE_EN. With the macro: result 33554431 and res_sat 1.
- ap_rst_n pulsed low mid-burst on requester 3 → outputs immediately at reset values. After release, with requesters 1 and 3 valid, the first grant goes to 1.
